// File: rtl/imem_arbiter_if.sv
// Bundle of the fetch, boot-loader and instruction-memory signals around
// imem_arbiter. The slave modport is the arbiter's view; the master modport
// is the surrounding system (CPU front end, loader and memory macro).
interface imem_arbiter_if #(
    parameter int ADDR_W = 12
);
    // CPU fetch port
    logic              fetch_req;
    logic [31:0]       fetch_pc;
    logic              is_jump;
    logic              is_stoll;
    logic              fetch_gnt;
    logic [31:0]       fetch_inst;
    logic              fetch_vld;

    // Boot loader port
    logic              ld_valid;
    logic [31:0]       ld_addr;
    logic [31:0]       ld_data;
    logic              ld_done;
    logic              ld_ready;
    logic              ld_err;
    logic              cpu_run;

    // Instruction memory port
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  fetch_req, fetch_pc, is_jump, is_stoll,
        output fetch_gnt, fetch_inst, fetch_vld,
        input  ld_valid, ld_addr, ld_data, ld_done,
        output ld_ready, ld_err, cpu_run,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output fetch_req, fetch_pc, is_jump, is_stoll,
        input  fetch_gnt, fetch_inst, fetch_vld,
        output ld_valid, ld_addr, ld_data, ld_done,
        input  ld_ready, ld_err, cpu_run,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: shares one single-port memory between the boot
// loader (writes) and the CPU fetch path (reads). After reset the block sits
// in LOAD until the loader signals completion, then moves to RUN and releases
// the CPU. Loader writes win over fetches in RUN, with a throttle that forces
// a fetch slot after four back-to-back loads.
module imem_arbiter #(
    parameter int ADDR_W = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    imem_arbiter_if.slave  bus
);

    localparam logic [0:0]  ST_LOAD   = 1'b0;
    localparam logic [0:0]  ST_RUN    = 1'b1;
    localparam logic [2:0]  BURST_MAX = 3'd4;
    // Byte-address bits that lie beyond the memory; any of them set marks a
    // load word as out of range.
    localparam logic [31:0] HI_MASK   = ~((32'h1 << (ADDR_W + 2)) - 32'h1);

    // Registered state
    logic [0:0]  state_q,     state_d;
    logic [2:0]  ld_cnt_q,    ld_cnt_d;
    logic        ld_err_q,    ld_err_d;
    logic        pend_q,      pend_d;
    logic        flush_q,     flush_d;
    logic        buf_vld_q,   buf_vld_d;
    logic [31:0] buf_inst_q,  buf_inst_d;
    logic        hold_vld_q,  hold_vld_d;
    logic [31:0] hold_inst_q, hold_inst_d;

    // Combinational decode
    logic        run;
    logic        ld_ready;
    logic        ld_acc;
    logic        ld_bad;
    logic        ld_wr;
    logic        fetch_gnt;
    logic        out_vld;
    logic [31:0] out_inst;

    // Byte-offset and out-of-window fetch_pc bits are intentionally dropped.
    logic        unused_pc_bits;
    assign unused_pc_bits = ^{bus.fetch_pc[31:ADDR_W+2], bus.fetch_pc[1:0]};

    // Handshake decode: loader acceptance, load validity and fetch grant.
    always_comb begin
        run      = (state_q == ST_RUN);
        ld_ready = 1'b1;
        if (run && (ld_cnt_q == BURST_MAX) && bus.fetch_req) begin
            ld_ready = 1'b0;
        end
        ld_acc    = bus.ld_valid & ld_ready;
        ld_bad    = (bus.ld_addr[1:0] != 2'b00) || ((bus.ld_addr & HI_MASK) != '0);
        ld_wr     = ld_acc & ~ld_bad;
        fetch_gnt = run & bus.fetch_req & ~bus.is_stoll & ~ld_acc;
    end

    // Memory port mux: accepted load write first, then fetch read.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (ld_wr) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = bus.ld_addr[ADDR_W+1:2];
            bus.mem_wdata = bus.ld_data;
        end else if (fetch_gnt) begin
            bus.mem_en    = 1'b1;
            bus.mem_addr  = bus.fetch_pc[ADDR_W+1:2];
        end
    end

    // Mode FSM, consecutive-load counter and sticky load-error flag.
    always_comb begin
        state_d = state_q;
        if (!run && bus.ld_done) begin
            state_d = ST_RUN;
        end

        ld_cnt_d = '0;
        if (run && ld_acc) begin
            ld_cnt_d = (ld_cnt_q == BURST_MAX) ? BURST_MAX : ld_cnt_q + 3'd1;
        end

        ld_err_d = ld_err_q | (ld_acc & ld_bad);
    end

    // Read return path. A stall freezes the outputs at their last value and
    // parks any returning word in buf_*; a jump seen during the stall is
    // remembered in flush_q and kills the parked word once the stall ends.
    always_comb begin
        out_vld    = 1'b0;
        out_inst   = '0;
        pend_d     = fetch_gnt & ~bus.is_jump;
        flush_d    = 1'b0;
        buf_vld_d  = buf_vld_q;
        buf_inst_d = buf_inst_q;

        if (bus.is_stoll) begin
            out_vld  = hold_vld_q;
            out_inst = hold_inst_q;
            flush_d  = flush_q | bus.is_jump;
            if (pend_q) begin
                buf_vld_d  = 1'b1;
                buf_inst_d = bus.mem_rdata;
            end
        end else begin
            buf_vld_d  = 1'b0;
            buf_inst_d = '0;
            if (!(bus.is_jump || flush_q)) begin
                if (buf_vld_q) begin
                    out_vld  = 1'b1;
                    out_inst = buf_inst_q;
                end else if (pend_q) begin
                    out_vld  = 1'b1;
                    out_inst = bus.mem_rdata;
                end
            end
        end

        hold_vld_d  = out_vld;
        hold_inst_d = out_inst;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            ld_cnt_q    <= '0;
            ld_err_q    <= 1'b0;
            pend_q      <= 1'b0;
            flush_q     <= 1'b0;
            buf_vld_q   <= 1'b0;
            buf_inst_q  <= '0;
            hold_vld_q  <= 1'b0;
            hold_inst_q <= '0;
        end else begin
            state_q     <= state_d;
            ld_cnt_q    <= ld_cnt_d;
            ld_err_q    <= ld_err_d;
            pend_q      <= pend_d;
            flush_q     <= flush_d;
            buf_vld_q   <= buf_vld_d;
            buf_inst_q  <= buf_inst_d;
            hold_vld_q  <= hold_vld_d;
            hold_inst_q <= hold_inst_d;
        end
    end

    // Output ports.
    always_comb begin
        bus.fetch_gnt  = fetch_gnt;
        bus.fetch_vld  = out_vld;
        bus.fetch_inst = out_inst;
        bus.ld_ready   = ld_ready;
        bus.ld_err     = ld_err_q;
        bus.cpu_run    = run;
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a small synchronous memory model.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_imem_arbiter;

    localparam int ADDR_W = 12;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    imem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    imem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Instruction memory model: write-through on mem_we, 1-cycle read.
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    logic [31:0] rdata;
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_en && !bus.mem_we) rdata <= mem[bus.mem_addr];
    end
    assign bus.mem_rdata = rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.fetch_req = 1'b0;
        bus.fetch_pc  = '0;
        bus.is_jump   = 1'b0;
        bus.is_stoll  = 1'b0;
        bus.ld_valid  = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_data   = '0;
        bus.ld_done   = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle_inputs();

        // Reset state
        #3;
        chk("rst_cpu_run",  32'(bus.cpu_run),  32'd0);
        chk("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
        chk("rst_vld",      32'(bus.fetch_vld), 32'd0);
        chk("rst_inst",     bus.fetch_inst,     32'd0);
        chk("rst_ld_err",   32'(bus.ld_err),   32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Boot load: word 0, word 1, fetch requests ignored in LOAD
        @(negedge clk);
        bus.ld_valid = 1'b1; bus.ld_addr = 32'h0; bus.ld_data = 32'h0000_0013;
        bus.fetch_req = 1'b1; bus.fetch_pc = 32'h4;
        #1;
        chk("l0_ready",  32'(bus.ld_ready), 32'd1);
        chk("l0_en",     32'(bus.mem_en),   32'd1);
        chk("l0_we",     32'(bus.mem_we),   32'd1);
        chk("l0_addr",   32'(bus.mem_addr), 32'd0);
        chk("l0_wdata",  bus.mem_wdata,     32'h0000_0013);
        chk("l0_gnt",    32'(bus.fetch_gnt), 32'd0);
        @(negedge clk);
        bus.ld_addr = 32'h4; bus.ld_data = 32'h0010_0093;
        #1;
        chk("l1_addr",   32'(bus.mem_addr), 32'd1);
        chk("l1_wdata",  bus.mem_wdata,     32'h0010_0093);
        @(negedge clk);
        bus.ld_valid = 1'b0; bus.ld_done = 1'b1; bus.fetch_req = 1'b0;
        #1;
        chk("done_run",  32'(bus.cpu_run), 32'd0);
        chk("done_en",   32'(bus.mem_en),  32'd0);
        @(negedge clk);
        bus.ld_done = 1'b0;
        #1;
        chk("run_on",    32'(bus.cpu_run), 32'd1);

        // Plain fetch of word 1
        @(negedge clk);
        bus.fetch_req = 1'b1; bus.fetch_pc = 32'h4;
        #1;
        chk("f_gnt",     32'(bus.fetch_gnt), 32'd1);
        chk("f_we",      32'(bus.mem_we),    32'd0);
        chk("f_addr",    32'(bus.mem_addr),  32'd1);
        chk("f_vld0",    32'(bus.fetch_vld), 32'd0);
        @(negedge clk);
        bus.fetch_req = 1'b0;
        #1;
        chk("f_vld1",    32'(bus.fetch_vld), 32'd1);
        chk("f_inst",    bus.fetch_inst,     32'h0010_0093);

        // Grant at 0x0 then jump flushes it
        @(negedge clk);
        bus.fetch_req = 1'b1; bus.fetch_pc = 32'h0;
        #1;
        chk("j_gnt",     32'(bus.fetch_gnt), 32'd1);
        chk("j_idle_vld", 32'(bus.fetch_vld), 32'd0);
        @(negedge clk);
        bus.fetch_req = 1'b0; bus.is_jump = 1'b1;
        #1;
        chk("j_vld",     32'(bus.fetch_vld), 32'd0);
        chk("j_inst",    bus.fetch_inst,     32'd0);

        // Stall for 3 cycles while a read is in flight
        @(negedge clk);
        bus.is_jump = 1'b0; bus.fetch_req = 1'b1; bus.fetch_pc = 32'h4;
        @(negedge clk);
        bus.fetch_pc = 32'h0;
        #1;
        chk("s_gnt",     32'(bus.fetch_gnt), 32'd1);
        chk("s_prior",   bus.fetch_inst,     32'h0010_0093);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.fetch_req = 1'b0; bus.is_stoll = 1'b1;
            #1;
            chk("s_hold_vld",  32'(bus.fetch_vld), 32'd1);
            chk("s_hold_inst", bus.fetch_inst,     32'h0010_0093);
            chk("s_no_gnt",    32'(bus.fetch_gnt), 32'd0);
        end
        @(negedge clk);
        bus.is_stoll = 1'b0;
        #1;
        chk("s_new_vld",  32'(bus.fetch_vld), 32'd1);
        chk("s_new_inst", bus.fetch_inst,     32'h0000_0013);
        @(negedge clk);
        #1;
        chk("s_idle_vld",  32'(bus.fetch_vld), 32'd0);
        chk("s_idle_inst", bus.fetch_inst,     32'd0);

        // fetch_pc wraps modulo the memory size
        @(negedge clk);
        bus.fetch_req = 1'b1; bus.fetch_pc = 32'h0000_4004;
        #1;
        chk("w_addr",    32'(bus.mem_addr), 32'd1);
        @(negedge clk);
        bus.fetch_pc = 32'h0;
        #1;
        chk("w_inst",    bus.fetch_inst, 32'h0010_0093);

        // Stall and jump together: hold, then flush when the stall ends
        @(negedge clk);
        bus.fetch_req = 1'b0; bus.is_stoll = 1'b1; bus.is_jump = 1'b1;
        #1;
        chk("sj_hold",   bus.fetch_inst, 32'h0010_0093);
        @(negedge clk);
        bus.is_stoll = 1'b0; bus.is_jump = 1'b0;
        #1;
        chk("sj_vld",    32'(bus.fetch_vld), 32'd0);
        chk("sj_inst",   bus.fetch_inst,     32'd0);

        // Load burst against a continuous fetch request
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.fetch_req = 1'b1; bus.fetch_pc = 32'h4;
            bus.ld_valid  = 1'b1;
            bus.ld_addr   = (k < 5) ? 32'h10 + 32'(4 * k) : 32'h20;
            bus.ld_data   = (k < 5) ? 32'hA000_0000 + 32'(k) : 32'hA000_0004;
            #1;
            if (k == 4) begin
                chk("b_throttle_ready", 32'(bus.ld_ready),  32'd0);
                chk("b_throttle_gnt",   32'(bus.fetch_gnt), 32'd1);
                chk("b_throttle_addr",  32'(bus.mem_addr),  32'd1);
            end else begin
                chk("b_ready",  32'(bus.ld_ready),  32'd1);
                chk("b_we",     32'(bus.mem_we),    32'd1);
                chk("b_gnt",    32'(bus.fetch_gnt), 32'd0);
                chk("b_addr",   32'(bus.mem_addr),  (k < 5) ? 32'd4 + 32'(k) : 32'd8);
            end
            if (k == 5) chk("b_ret_inst", bus.fetch_inst, 32'h0010_0093);
        end
        @(negedge clk);
        bus.ld_valid = 1'b0; bus.fetch_pc = 32'h20;
        @(negedge clk);
        bus.fetch_req = 1'b0;
        #1;
        chk("b_word8",   bus.fetch_inst, 32'hA000_0004);

        // Misaligned load is dropped and flags ld_err
        @(negedge clk);
        bus.ld_valid = 1'b1; bus.ld_addr = 32'h2; bus.ld_data = 32'h0000_0BAD;
        #1;
        chk("e_ready",   32'(bus.ld_ready), 32'd1);
        chk("e_en",      32'(bus.mem_en),   32'd0);
        chk("e_err0",    32'(bus.ld_err),   32'd0);
        @(negedge clk);
        bus.ld_valid = 1'b0; bus.fetch_req = 1'b1; bus.fetch_pc = 32'h0;
        #1;
        chk("e_err1",    32'(bus.ld_err),   32'd1);
        @(negedge clk);
        bus.fetch_req = 1'b0;
        #1;
        chk("e_word0",   bus.fetch_inst,    32'h0000_0013);
        chk("e_err_sticky", 32'(bus.ld_err), 32'd1);

        // Reset during an in-flight fetch
        @(negedge clk);
        bus.fetch_req = 1'b1; bus.fetch_pc = 32'h4;
        #1;
        chk("r_gnt",     32'(bus.fetch_gnt), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("r_run",     32'(bus.cpu_run),  32'd0);
        chk("r_err",     32'(bus.ld_err),   32'd0);
        chk("r_ready",   32'(bus.ld_ready), 32'd1);
        chk("r_gnt0",    32'(bus.fetch_gnt), 32'd0);
        @(negedge clk);
        bus.fetch_req = 1'b0;
        #1;
        chk("r_vld",     32'(bus.fetch_vld), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("r_vld_rel", 32'(bus.fetch_vld), 32'd0);
        chk("r_load",    32'(bus.cpu_run),   32'd0);

        // Out-of-range load in LOAD state
        @(negedge clk);
        bus.ld_valid = 1'b1; bus.ld_addr = 32'h0000_4000; bus.ld_data = 32'h1234_5678;
        #1;
        chk("o_en",      32'(bus.mem_en),   32'd0);
        chk("o_ready",   32'(bus.ld_ready), 32'd1);

        // Load coincident with ld_done: written, then RUN
        @(negedge clk);
        bus.ld_addr = 32'h8; bus.ld_data = 32'hCAFE_0001; bus.ld_done = 1'b1;
        #1;
        chk("o_err",     32'(bus.ld_err),   32'd1);
        chk("d_en",      32'(bus.mem_en),   32'd1);
        chk("d_addr",    32'(bus.mem_addr), 32'd2);
        chk("d_run0",    32'(bus.cpu_run),  32'd0);
        @(negedge clk);
        bus.ld_valid = 1'b0; bus.ld_done = 1'b0;
        bus.fetch_req = 1'b1; bus.fetch_pc = 32'h8;
        #1;
        chk("d_run1",    32'(bus.cpu_run),   32'd1);
        chk("d_gnt",     32'(bus.fetch_gnt), 32'd1);
        @(negedge clk);
        bus.fetch_req = 1'b0;
        #1;
        chk("d_inst",    bus.fetch_inst,     32'hCAFE_0001);
        chk("d_err",     32'(bus.ld_err),    32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
